// File: rtl/ahb_rsa2048_slave_if.sv
// AHB-Lite bus bundle between a master/BFM and the RSA-2048 slave front-end.
interface ahb_rsa2048_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_rsa2048_slave.sv
// AHB-Lite slave front-end for the 2048-bit modexp core: word-serial operand
// load, one-cycle launch pulse, DONE status/interrupt and word-serial readout.
module ahb_rsa2048_slave #(
  parameter int WORDS = 64
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  ahb_rsa2048_slave_if.slave   bus,
  output logic [WORDS*32-1:0]  x_o,
  output logic                 start_o,
  input  logic [WORDS*32-1:0]  result_i,
  input  logic                 result_valid_i,
  output logic                 irq_o
);

  localparam int OPW = WORDS * 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic           capture;
  logic           vld_p1;
  logic           write_p1;
  logic [2:0]     addr_p1;
  logic [OPW-1:0] x;
  logic [OPW-1:0] res;
  logic [7:0]     wr_cnt;
  logic [7:0]     rd_cnt;
  logic           done;
  logic           err;
  logic           start;
  logic           ctrl_wr, info_wr, data_wr, data_rd, load_last;
  logic [31:0]    hrdata;
  logic           unused;

  assign unused  = ^{bus.HADDR[31:5], bus.HADDR[1:0], bus.HTRANS[0]};
  assign capture = bus.HSEL & bus.HREADY & bus.HTRANS[1] & (bus.HSIZE == 3'b010);

  // Address phase -> data phase
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      vld_p1   <= 1'b0;
      write_p1 <= 1'b0;
      addr_p1  <= 3'd0;
    end else if (bus.HREADY) begin
      vld_p1   <= capture;
      write_p1 <= bus.HWRITE;
      addr_p1  <= bus.HADDR[4:2];
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ctrl_wr) state_nxt = LOAD;
      LOAD:    if (ctrl_wr) state_nxt = LOAD;
               else if (load_last) state_nxt = RUN;
      RUN:     if (result_valid_i) state_nxt = DONE;
      DONE:    if (ctrl_wr) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  // Data-phase strobes and the combinational read mux
  always_comb begin
    ctrl_wr   = vld_p1 &  write_p1 & (addr_p1 == 3'd0);
    info_wr   = vld_p1 &  write_p1 & (addr_p1 == 3'd2);
    data_wr   = vld_p1 &  write_p1 & (addr_p1 == 3'd4);
    data_rd   = vld_p1 & ~write_p1 & (addr_p1 == 3'd4);
    load_last = data_wr & (state == LOAD) & (wr_cnt == 8'(WORDS - 1));
    hrdata    = 32'd0;
    if (vld_p1 && !write_p1) begin
      case (addr_p1)
        3'd1:    hrdata = {31'd0, done};
        3'd2:    hrdata = {err, 7'd0, state, 6'd0, rd_cnt, wr_cnt};
        3'd4:    hrdata = (state == DONE) ? res[31:0] : 32'd0;
        default: hrdata = 32'd0;
      endcase
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      x      <= '0;
      res    <= '0;
      wr_cnt <= 8'd0;
      rd_cnt <= 8'd0;
      done   <= 1'b0;
      err    <= 1'b0;
      start  <= 1'b0;
    end else begin
      start <= load_last;
      if (ctrl_wr) begin
        if (state == RUN) begin
          err <= 1'b1;
        end else begin
          wr_cnt <= 8'd0;
          rd_cnt <= 8'd0;
          done   <= 1'b0;
        end
      end
      if (info_wr) err <= 1'b0;
      if (data_wr) begin
        if (state == LOAD) begin
          x      <= {bus.HWDATA, x[OPW-1:32]};
          wr_cnt <= wr_cnt + 8'd1;
        end else if (state == RUN) begin
          err <= 1'b1;
        end
      end
      // Rotating res keeps the result intact across a full readout lap
      if (data_rd && state == DONE) begin
        res    <= {res[31:0], res[OPW-1:32]};
        rd_cnt <= (rd_cnt == 8'(WORDS - 1)) ? 8'd0 : rd_cnt + 8'd1;
      end
      if (result_valid_i && state == RUN) begin
        res  <= result_i;
        done <= 1'b1;
      end
    end
  end

  assign bus.HREADYOUT = 1'b1;
  assign bus.HRESP     = 2'b00;
  assign bus.HRDATA    = hrdata;
  assign x_o           = x;
  assign start_o       = start;
  assign irq_o         = done;

endmodule

// File: tb/tb_ahb_rsa2048_slave.sv
// Directed bench for ahb_rsa2048_slave: transaction-level model plus a
// per-cycle compare process and hand-computed literal expectations.
module tb_ahb_rsa2048_slave;
  localparam int WORDS = 64;
  localparam int OPW   = WORDS * 32;
  localparam logic [1:0] S_IDLE = 2'd0, S_LOAD = 2'd1, S_RUN = 2'd2, S_DONE = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ahb_rsa2048_slave_if bus();
  logic [OPW-1:0] x_o;
  logic [OPW-1:0] result_i;
  logic           start_o, result_valid_i, irq_o;

  ahb_rsa2048_slave #(.WORDS(WORDS)) dut (
    .HCLK(clk), .HRESET(rst), .bus(bus), .x_o(x_o), .start_o(start_o),
    .result_i(result_i), .result_valid_i(result_valid_i), .irq_o(irq_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model state
  logic [1:0]  m_state;
  bit          m_done, m_err;
  int          m_wr, m_rd;
  logic [31:0] m_q[$];
  logic [31:0] m_res[WORDS];
  logic [31:0] rw[WORDS];
  int          m_start_cyc = -1;
  logic [31:0] exp_rdata = 32'd0;
  bit          chk_en = 1'b0;
  bit          rv_dphase = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [OPW-1:0] m_x();
    logic [OPW-1:0] v = '0;
    int n = m_q.size();
    for (int i = 0; i < WORDS; i++)
      if (n - WORDS + i >= 0) v[i*32 +: 32] = m_q[n - WORDS + i];
    return v;
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd1:    return {31'd0, m_done};
      3'd2:    return {m_err, 7'd0, m_state, 6'd0, 8'(m_rd), 8'(m_wr)};
      3'd4:    return (m_state == S_DONE) ? m_res[m_rd] : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_reset();
    m_state = S_IDLE; m_done = 0; m_err = 0; m_wr = 0; m_rd = 0;
    m_q.delete();
    for (int i = 0; i < WORDS; i++) m_res[i] = 32'd0;
    m_start_cyc = -1;
  endtask

  task automatic m_apply(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                         input logic [31:0] wdata, input bit rv);
    logic [1:0] pre = m_state;
    if (size == 3'b010) begin
      if (wr) begin
        case (addr[4:2])
          3'd0: if (pre == S_RUN) m_err = 1;
                else begin m_wr = 0; m_rd = 0; m_done = 0; m_state = S_LOAD; end
          3'd2: m_err = 0;
          3'd4: if (pre == S_LOAD) begin
                  m_q.push_back(wdata);
                  m_wr++;
                  if (m_wr == WORDS) begin m_state = S_RUN; m_start_cyc = cyc; end
                end else if (pre == S_RUN) m_err = 1;
          default: ;
        endcase
      end else if (addr[4:2] == 3'd4 && pre == S_DONE) begin
        m_rd = (m_rd + 1) % WORDS;
      end
    end
    if (rv && pre == S_RUN) begin
      m_state = S_DONE; m_done = 1;
      for (int i = 0; i < WORDS; i++) m_res[i] = rw[i];
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      logic [OPW-1:0] mx;
      chk("hreadyout", {31'd0, bus.HREADYOUT}, 32'd1);
      chk("hresp", {30'd0, bus.HRESP}, 32'd0);
      chk("hrdata", bus.HRDATA, exp_rdata);
      chk("irq", {31'd0, irq_o}, {31'd0, m_done});
      chk("start", {31'd0, start_o}, {31'd0, (cyc == m_start_cyc)});
      mx = m_x();
      checks++;
      if (x_o !== mx) begin
        errors++;
        for (int i = 0; i < WORDS; i++)
          if (x_o[i*32 +: 32] !== mx[i*32 +: 32]) begin
            $display("FAIL x_o word %0d actual=%h expected=%h (t=%0t)", i, x_o[i*32 +: 32], mx[i*32 +: 32], $time);
            break;
          end
      end
    end
  end

  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata, output logic [31:0] rdata);
    bus.HSEL = 1; bus.HADDR = addr; bus.HTRANS = 2'b10; bus.HWRITE = wr; bus.HSIZE = size;
    @(posedge clk); #1;
    bus.HSEL = 0; bus.HTRANS = 2'b00; bus.HWDATA = wdata;
    result_valid_i = rv_dphase;
    exp_rdata = (!wr && size == 3'b010) ? m_read(addr[4:2]) : 32'd0;
    @(negedge clk);
    rdata = bus.HRDATA;
    @(posedge clk); #1;
    result_valid_i = 0;
    m_apply(wr, addr, size, wdata, rv_dphase);
    exp_rdata = 32'd0;
  endtask

  task automatic wr32(input logic [31:0] addr, input logic [31:0] d);
    logic [31:0] r;
    xfer(1, addr, 3'b010, d, r);
  endtask

  task automatic rd32(input logic [31:0] addr, output logic [31:0] r);
    xfer(0, addr, 3'b010, 32'd0, r);
  endtask

  task automatic load(input logic [31:0] base, input logic [31:0] step);
    for (int i = 0; i < WORDS; i++) wr32(32'h10, base + step * i);
  endtask

  task automatic set_result(input logic [31:0] base);
    for (int i = 0; i < WORDS; i++) begin
      rw[i] = base | i;
      result_i[i*32 +: 32] = rw[i];
    end
  endtask

  task automatic core_done();
    result_valid_i = 1;
    @(posedge clk); #1;
    result_valid_i = 0;
    m_apply(0, 32'h0, 3'b000, 32'd0, 1'b1);
  endtask

  logic [31:0] rd_words[WORDS+1];

  // Pipelined DATA reads: address phase of read i overlaps data phase of read i-1
  task automatic read_burst(input int n);
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        bus.HSEL = 1; bus.HADDR = 32'h10; bus.HTRANS = 2'b10; bus.HWRITE = 0; bus.HSIZE = 3'b010;
      end else begin
        bus.HSEL = 0; bus.HTRANS = 2'b00;
      end
      exp_rdata = (i > 0) ? m_read(3'd4) : 32'd0;
      @(negedge clk);
      if (i > 0) rd_words[i-1] = bus.HRDATA;
      @(posedge clk); #1;
      if (i > 0) m_apply(0, 32'h10, 3'b010, 32'd0, 1'b0);
    end
    exp_rdata = 32'd0;
  endtask

  initial begin
    logic [31:0] r;
    bus.HSEL = 0; bus.HADDR = 0; bus.HTRANS = 0; bus.HWRITE = 0; bus.HSIZE = 0;
    bus.HWDATA = 0; bus.HREADY = 1;
    result_i = '0; result_valid_i = 0;
    m_reset();

    @(posedge clk); #1;
    chk("rst_hreadyout", {31'd0, bus.HREADYOUT}, 32'd1);
    chk("rst_hresp", {30'd0, bus.HRESP}, 32'd0);
    chk("rst_hrdata", bus.HRDATA, 32'd0);
    chk("rst_start", {31'd0, start_o}, 32'd0);
    chk("rst_x", {31'd0, (x_o == '0)}, 32'd1);
    chk("rst_irq", {31'd0, irq_o}, 32'd0);
    @(posedge clk); #1;
    rst = 0;
    chk_en = 1;
    rd32(32'h08, r); chk("info_after_rst", r, 32'h0000_0000);

    // Reset while the launch pulse is high
    wr32(32'h00, 32'hFFFF_FFFF);
    load(32'h100, 32'd1);
    chk("start_before_rst", {31'd0, start_o}, 32'd1);
    rst = 1;
    m_reset();
    #1;
    chk("start_dropped", {31'd0, start_o}, 32'd0);
    chk("x_cleared", {31'd0, (x_o == '0)}, 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
    rd32(32'h04, r); chk("status_after_rst", r, 32'd0);
    rd32(32'h08, r); chk("info_zero_after_rst", r, 32'd0);

    // Arm, illegal byte accesses, full load
    wr32(32'h00, 32'hFFFF_FFFF);
    xfer(1, 32'h10, 3'b000, 32'h99, r);
    rd32(32'h08, r); chk("info_byte_write", r, 32'h0040_0000);
    xfer(0, 32'h08, 3'b000, 32'd0, r); chk("byte_read_zero", r, 32'd0);
    load(32'd1, 32'd1);
    chk("x_lo", x_o[31:0], 32'h1);
    chk("x_hi", x_o[OPW-1 -: 32], 32'h40);
    chk("start_pulse", {31'd0, start_o}, 32'd1);
    @(posedge clk); #1;
    chk("start_one_cycle", {31'd0, start_o}, 32'd0);
    rd32(32'h04, r); chk("status_run", r, 32'd0);
    rd32(32'h08, r); chk("info_run", r, 32'h0080_0040);

    // Illegal DATA write in RUN, then clear err
    wr32(32'h10, 32'hDEAD_BEEF);
    rd32(32'h08, r); chk("info_err_set", r, 32'h8080_0040);
    wr32(32'h08, 32'd0);
    rd32(32'h08, r); chk("info_err_clr", r, 32'h0080_0040);

    // Completion lands during a STATUS data phase
    set_result(32'hA5A5_0000);
    rv_dphase = 1;
    rd32(32'h04, r); chk("status_on_done_edge", r, 32'd0);
    rv_dphase = 0;
    rd32(32'h04, r); chk("status_done", r, 32'd1);
    chk("irq_done", {31'd0, irq_o}, 32'd1);

    read_burst(WORDS + 1);
    chk("rd_word0", rd_words[0], 32'hA5A5_0000);
    chk("rd_word1", rd_words[1], 32'hA5A5_0001);
    chk("rd_word63", rd_words[63], 32'hA5A5_003F);
    chk("rd_wrap", rd_words[64], 32'hA5A5_0000);

    // Completion outside RUN is ignored
    set_result(32'h1111_0000);
    core_done();
    rd32(32'h10, r); chk("rv_ignored", r, 32'hA5A5_0001);

    // Second run
    wr32(32'h00, 32'd0);
    rd32(32'h04, r); chk("status_rearm", r, 32'd0);
    chk("irq_rearm", {31'd0, irq_o}, 32'd0);
    rd32(32'h08, r); chk("info_rearm", r, 32'h0040_0000);
    load(32'd7, 32'd3);
    chk("start_second", {31'd0, start_o}, 32'd1);
    chk("x_lo_second", x_o[31:0], 32'd7);

    // Completion coincides with a CTRL write in RUN
    set_result(32'h1234_0000);
    rv_dphase = 1;
    wr32(32'h00, 32'h1);
    rv_dphase = 0;
    rd32(32'h08, r); chk("info_simul", r, 32'h80C0_0040);
    rd32(32'h04, r); chk("status_simul", r, 32'd1);
    rd32(32'h10, r); chk("rd_simul", r, 32'h1234_0000);

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
